// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI slave core and its pin synchroniser.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
//
// Contents:
//   spi_state_t  - two-state frame FSM encoding (IDLE, ACTIVE)
//   DATA_W_DEF   - default frame width used by the core
//   bit_cnt_w()  - width of a counter that must hold 0..data_w inclusive
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int DATA_W_DEF    = 16;
    localparam int BIT_CNT_W_DEF = $clog2(DATA_W_DEF + 1);

    // The bit counter has to represent DATA_W itself (the "frame full" value),
    // so it needs one more code than the number of bit positions.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection on the synced level.
// Latency: SYNC_STAGES clk from pin change to o_rise/o_fall asserting (combinational off the last stage).
// Backpressure: none; edges are single-clk pulses and are never held.
//
// Ports:
//   i_clk   - local clock
//   i_rst   - asynchronous active-high reset
//   i_pin   - raw asynchronous pin
//   o_rise  - one-clk pulse when the synced pin goes 0 -> 1
//   o_fall  - one-clk pulse when the synced pin goes 1 -> 0
module spi_pin_sync
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Every stage and the edge-history flop reset to the same value so that
    // leaving reset never fabricates an edge on its own.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: oversamples sclk/mosi/ss, deserialises MOSI into DATA_W-bit words and serialises a TX word onto MISO.
// Latency: SYNC_STAGES+1 clk from any SPI pin change to the corresponding action; rx_valid one clk after the last sample.
// Backpressure: TX side is valid/ready through a one-word holding register; RX side has none (rx_valid is a pulse).
//
// Ports:
//   clk, rst            - local clock (>= 4x sclk) and asynchronous active-high reset
//   sclk, mosi, ss      - SPI bus from the master (asynchronous to clk), ss active low
//   miso                - SPI data to the master, IDLE_MISO while deselected
//   tx_data/valid/ready - word for the next frame; accepted on tx_valid && tx_ready
//   rx_data, rx_valid   - last complete word, updated with a one-clk rx_valid pulse
//   tx_underrun         - one-clk pulse: a frame began while the holding register was empty
//   frame_err           - one-clk pulse: ss rose part-way through a word
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int   DATA_W      = DATA_W_DEF,
    parameter bit   CPOL        = 1'b0,
    parameter bit   CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int               CNT_W    = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_lead;
    logic w_trail;
    logic w_mosi_s;

    // sclk history starts at its idle level so reset release is edge-free.
    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (CPOL)
    ) u_sync_sclk (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // ss history starts low: if the master is still holding ss low when reset
    // drops, no fall is seen, so a frame can only begin after ss has been
    // observed high and then falls again.
    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_ss (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (ss),
        .o_rise (w_ss_rise),
        .o_fall (w_ss_fall)
    );

    // mosi needs the same depth as sclk so that data and edge line up, but
    // no edge detection.
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead   = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = CPOL ? w_sclk_rise : w_sclk_fall;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift_tx;
    logic [DATA_W-1:0] r_shift_rx;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic              r_miso;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_underrun;
    logic              r_frame_err;
    logic              r_udr_pend;

    logic              w_start;
    logic              w_frame_done;
    logic              w_load;
    logic              w_accept;
    logic [DATA_W-1:0] w_tx_word;

    assign w_start      = (r_state == IDLE) && w_ss_fall;
    assign w_frame_done = (r_state == ACTIVE) && (r_bit_cnt == CNT_FULL);
    // A completed word with ss still low is a back-to-back frame start.
    assign w_load       = w_start || (w_frame_done && !w_ss_rise);
    assign w_accept     = tx_valid && !r_hold_full;
    // An empty holding register transmits all zeros.
    assign w_tx_word    = r_hold_full ? r_hold : '0;

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    // A load reads the old contents in the same clk that a new word may be
    // written, so a write into an empty register during a start lands for the
    // following frame rather than the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= tx_data;
            end
            r_hold_full <= (r_hold_full && !w_load) || w_accept;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, shift registers, bit counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift_tx  <= '0;
            r_shift_rx  <= '0;
            r_miso      <= IDLE_MISO;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            r_udr_pend  <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_miso    <= IDLE_MISO;
                    if (w_ss_fall) begin
                        r_state    <= ACTIVE;
                        r_underrun <= !r_hold_full;
                        r_udr_pend <= 1'b0;
                        // r_shift_tx always holds the bits not yet driven.
                        // In CPHA=0 the MSB goes out before the first sclk
                        // edge, so it is consumed here.
                        if (!CPHA) begin
                            r_miso     <= w_tx_word[DATA_W-1];
                            r_shift_tx <= w_tx_word << 1;
                        end else begin
                            r_shift_tx <= w_tx_word;
                        end
                    end
                end

                ACTIVE: begin
                    if (w_frame_done) begin
                        r_rx_data  <= r_shift_rx;
                        r_rx_valid <= 1'b1;
                        r_bit_cnt  <= '0;
                        if (w_ss_rise) begin
                            r_state    <= IDLE;
                            r_miso     <= IDLE_MISO;
                            r_udr_pend <= 1'b0;
                        end else begin
                            // Back-to-back reload: the new MSB is still
                            // undriven (CPHA=0 drives it on the trailing edge
                            // closing this word, CPHA=1 on the next lead).
                            // An underrun here is only reported once the next
                            // word actually starts clocking, so a master that
                            // simply ends the transfer does not see a spurious
                            // pulse.
                            r_shift_tx <= w_tx_word;
                            r_udr_pend <= !r_hold_full;
                        end
                    end else if (w_ss_rise) begin
                        r_frame_err <= (r_bit_cnt != '0);
                        r_state     <= IDLE;
                        r_miso      <= IDLE_MISO;
                        r_bit_cnt   <= '0;
                        r_udr_pend  <= 1'b0;
                    end else if (w_lead) begin
                        if (r_udr_pend) begin
                            r_underrun <= 1'b1;
                            r_udr_pend <= 1'b0;
                        end
                        if (!CPHA) begin
                            r_shift_rx <= {r_shift_rx[DATA_W-2:0], w_mosi_s};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end else begin
                            r_miso     <= r_shift_tx[DATA_W-1];
                            r_shift_tx <= r_shift_tx << 1;
                        end
                    end else if (w_trail) begin
                        if (!CPHA) begin
                            if (r_bit_cnt < CNT_FULL) begin
                                r_miso     <= r_shift_tx[DATA_W-1];
                                r_shift_tx <= r_shift_tx << 1;
                            end
                        end else begin
                            r_shift_rx <= {r_shift_rx[DATA_W-2:0], w_mosi_s};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign miso        = r_miso;
    assign tx_ready    = !r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_core.sv
`timescale 1ns/1ps
module tb_spi_slave_core;

    localparam int W = 16;
    localparam int H = 80;   // half sclk period: 8 clk

    logic clk = 1'b0;
    logic rst;

    // mode 0 bus
    logic          sclk0, mosi0, ss0, miso0;
    logic [W-1:0]  tx_data0, rx_data0;
    logic          tx_valid0, tx_ready0, rx_valid0, udr0, ferr0;
    // mode 3 bus
    logic          sclk3, mosi3, ss3, miso3;
    logic [W-1:0]  tx_data3, rx_data3;
    logic          tx_valid3, tx_ready3, rx_valid3, udr3, ferr3;

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_W(W), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sclk(sclk0), .mosi(mosi0), .ss(ss0), .miso(miso0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_underrun(udr0), .frame_err(ferr0)
    );

    spi_slave_core #(.DATA_W(W), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut3 (
        .clk(clk), .rst(rst), .sclk(sclk3), .mosi(mosi3), .ss(ss3), .miso(miso3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .tx_underrun(udr3), .frame_err(ferr3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues: expected RX words (per DUT) and expected MISO words.
    logic [W-1:0] rx_exp0_q[$];
    logic [W-1:0] rx_exp3_q[$];
    logic [W-1:0] tx_exp_q[$];

    // Pulse monitor, sampled on the falling clk edge.
    int           rxv_cnt0 = 0, udr_cnt0 = 0, ferr_cnt0 = 0, rxv_cnt3 = 0;
    logic [W-1:0] rx_got0[64];
    logic [W-1:0] rx_got3[64];

    always @(negedge clk) begin
        if (rx_valid0 === 1'b1) begin
            rx_got0[rxv_cnt0 % 64] = rx_data0;
            rxv_cnt0++;
        end
        if (udr0 === 1'b1)  udr_cnt0++;
        if (ferr0 === 1'b1) ferr_cnt0++;
        if (rx_valid3 === 1'b1) begin
            rx_got3[rxv_cnt3 % 64] = rx_data3;
            rxv_cnt3++;
        end
    end

    logic [31:0] rd_b2b;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic load_tx(input bit m3, input logic [W-1:0] w);
        int t = 0;
        @(negedge clk);
        while (((m3 ? tx_ready3 : tx_ready0) !== 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL load_tx_ready: tx_ready stayed %b for %0d clk, required 1", m3 ? tx_ready3 : tx_ready0, t);
        end
        if (m3) begin tx_data3 = w; tx_valid3 = 1'b1; end
        else    begin tx_data0 = w; tx_valid0 = 1'b1; end
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
    endtask

    // Master BFM: MSB first, nbits bits; mode 0 (m3=0) or mode 3 (m3=1).
    task automatic xfer(input bit m3, input logic [31:0] wr, input int nbits, input bit raise, output logic [31:0] rd);
        rd = '0;
        if (!m3) begin
            mosi0 = wr[nbits-1];
            ss0   = 1'b0;
            #H;
            for (int i = 0; i < nbits; i++) begin
                mosi0 = wr[nbits-1-i];
                #H;
                rd = {rd[30:0], miso0};
                sclk0 = 1'b1;
                #H;
                sclk0 = 1'b0;
            end
            if (raise) begin #H; ss0 = 1'b1; #(4*H); end
        end else begin
            ss3 = 1'b0;
            #H;
            for (int i = 0; i < nbits; i++) begin
                sclk3 = 1'b0;
                mosi3 = wr[nbits-1-i];
                #H;
                rd = {rd[30:0], miso3};
                sclk3 = 1'b1;
                #H;
            end
            if (raise) begin #H; ss3 = 1'b1; #(4*H); end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sclk0 = 1'b0; mosi0 = 1'b0; ss0 = 1'b1; tx_data0 = '0; tx_valid0 = 1'b0;
        sclk3 = 1'b1; mosi3 = 1'b0; ss3 = 1'b1; tx_data3 = '0; tx_valid3 = 1'b0;
        #33;
        n_checks++; if (miso0 !== 1'b0)     begin n_fail++; $display("FAIL reset_miso0: got %b want 0", miso0); end
        n_checks++; if (tx_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready0: got %b want 1", tx_ready0); end
        n_checks++; if (rx_data0 !== 16'h0) begin n_fail++; $display("FAIL reset_rx_data0: got %h want 0000", rx_data0); end
        n_checks++; if (rx_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid0: got %b want 0", rx_valid0); end
        n_checks++; if (udr0 !== 1'b0)      begin n_fail++; $display("FAIL reset_underrun0: got %b want 0", udr0); end
        n_checks++; if (ferr0 !== 1'b0)     begin n_fail++; $display("FAIL reset_frame_err0: got %b want 0", ferr0); end
        n_checks++; if (miso3 !== 1'b0)     begin n_fail++; $display("FAIL reset_miso3: got %b want 0", miso3); end
        n_checks++; if (tx_ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready3: got %b want 1", tx_ready3); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (ferr_cnt0 + udr_cnt0 + rxv_cnt0 !== 0) begin n_fail++; $display("FAIL reset_idle_pulses: got %0d pulses want 0", ferr_cnt0 + udr_cnt0 + rxv_cnt0); end
    endtask

    task automatic test_mode0;
        logic [31:0] rd;
        int b, u;
        load_tx(0, 16'h3C5A);
        tx_exp_q.push_back(16'h3C5A);
        n_checks++; if (tx_ready0 !== 1'b0) begin n_fail++; $display("FAIL mode0_hold_full: tx_ready got %b want 0", tx_ready0); end
        rx_exp0_q.push_back(16'hA5C3);
        b = rxv_cnt0; u = udr_cnt0;
        xfer(0, 32'h0000A5C3, 16, 1, rd);
        n_checks++; if (rxv_cnt0 - b !== 1) begin n_fail++; $display("FAIL mode0_rx_pulses: got %0d want 1", rxv_cnt0 - b); end
        while (b < rxv_cnt0 && rx_exp0_q.size() > 0) begin
            logic [W-1:0] e = rx_exp0_q.pop_front();
            n_checks++; if (rx_got0[b % 64] !== e) begin n_fail++; $display("FAIL mode0_rx_data: got %h want %h", rx_got0[b % 64], e); end
            b++;
        end
        begin
            logic [W-1:0] e = tx_exp_q.pop_front();
            n_checks++; if (rd[15:0] !== e) begin n_fail++; $display("FAIL mode0_miso_word: got %h want %h", rd[15:0], e); end
        end
        n_checks++; if (udr_cnt0 - u !== 0) begin n_fail++; $display("FAIL mode0_no_underrun: got %0d want 0", udr_cnt0 - u); end
        n_checks++; if (tx_ready0 !== 1'b1) begin n_fail++; $display("FAIL mode0_hold_freed: tx_ready got %b want 1", tx_ready0); end
    endtask

    task automatic test_mode3;
        logic [31:0] rd;
        int b;
        load_tx(1, 16'hFFFF);
        tx_exp_q.push_back(16'hFFFF);
        rx_exp3_q.push_back(16'h0001);
        b = rxv_cnt3;
        xfer(1, 32'h00000001, 16, 1, rd);
        n_checks++; if (rxv_cnt3 - b !== 1) begin n_fail++; $display("FAIL mode3_rx_pulses: got %0d want 1", rxv_cnt3 - b); end
        while (b < rxv_cnt3 && rx_exp3_q.size() > 0) begin
            logic [W-1:0] e = rx_exp3_q.pop_front();
            n_checks++; if (rx_got3[b % 64] !== e) begin n_fail++; $display("FAIL mode3_rx_data: got %h want %h", rx_got3[b % 64], e); end
            b++;
        end
        begin
            logic [W-1:0] e = tx_exp_q.pop_front();
            n_checks++; if (rd[15:0] !== e) begin n_fail++; $display("FAIL mode3_miso_word: got %h want %h", rd[15:0], e); end
        end
        n_checks++; if (miso3 !== 1'b0) begin n_fail++; $display("FAIL mode3_idle_miso: got %b want 0", miso3); end
    endtask

    task automatic test_underrun;
        logic [31:0] rd;
        int b, u;
        tx_exp_q.push_back(16'h0000);
        rx_exp0_q.push_back(16'h1234);
        b = rxv_cnt0; u = udr_cnt0;
        xfer(0, 32'h00001234, 16, 1, rd);
        n_checks++; if (udr_cnt0 - u !== 1) begin n_fail++; $display("FAIL underrun_pulses: got %0d want 1", udr_cnt0 - u); end
        n_checks++; if (rxv_cnt0 - b !== 1) begin n_fail++; $display("FAIL underrun_rx_pulses: got %0d want 1", rxv_cnt0 - b); end
        while (b < rxv_cnt0 && rx_exp0_q.size() > 0) begin
            logic [W-1:0] e = rx_exp0_q.pop_front();
            n_checks++; if (rx_got0[b % 64] !== e) begin n_fail++; $display("FAIL underrun_rx_data: got %h want %h", rx_got0[b % 64], e); end
            b++;
        end
        begin
            logic [W-1:0] e = tx_exp_q.pop_front();
            n_checks++; if (rd[15:0] !== e) begin n_fail++; $display("FAIL underrun_miso_word: got %h want %h", rd[15:0], e); end
        end
    endtask

    task automatic test_frame_err;
        logic [31:0] rd;
        int b, f;
        b = rxv_cnt0; f = ferr_cnt0;
        xfer(0, 32'h000000C3, 8, 1, rd);
        n_checks++; if (ferr_cnt0 - f !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt0 - f); end
        n_checks++; if (rxv_cnt0 - b !== 0) begin n_fail++; $display("FAIL ferr_no_rx: got %0d want 0", rxv_cnt0 - b); end
        n_checks++; if (rx_data0 !== 16'h1234) begin n_fail++; $display("FAIL ferr_rx_held: got %h want 1234", rx_data0); end
        n_checks++; if (miso0 !== 1'b0) begin n_fail++; $display("FAIL ferr_idle_miso: got %b want 0", miso0); end
        rx_exp0_q.push_back(16'hBEEF);
        f = ferr_cnt0;
        xfer(0, 32'h0000BEEF, 16, 1, rd);
        n_checks++; if (rxv_cnt0 - b !== 1) begin n_fail++; $display("FAIL ferr_next_rx_pulses: got %0d want 1", rxv_cnt0 - b); end
        while (b < rxv_cnt0 && rx_exp0_q.size() > 0) begin
            logic [W-1:0] e = rx_exp0_q.pop_front();
            n_checks++; if (rx_got0[b % 64] !== e) begin n_fail++; $display("FAIL ferr_next_rx_data: got %h want %h", rx_got0[b % 64], e); end
            b++;
        end
        n_checks++; if (ferr_cnt0 - f !== 0) begin n_fail++; $display("FAIL ferr_next_clean: got %0d want 0", ferr_cnt0 - f); end
    endtask

    task automatic test_back_to_back;
        int b, u;
        load_tx(0, 16'hAAAA);
        tx_exp_q.push_back(16'hAAAA);
        tx_exp_q.push_back(16'h5555);
        rx_exp0_q.push_back(16'h1357);
        rx_exp0_q.push_back(16'h9BDF);
        b = rxv_cnt0; u = udr_cnt0;
        fork
            xfer(0, 32'h13579BDF, 32, 1, rd_b2b);
            begin
                #(H*10);
                load_tx(0, 16'h5555);
            end
        join
        n_checks++; if (rxv_cnt0 - b !== 2) begin n_fail++; $display("FAIL b2b_rx_pulses: got %0d want 2", rxv_cnt0 - b); end
        while (b < rxv_cnt0 && rx_exp0_q.size() > 0) begin
            logic [W-1:0] e = rx_exp0_q.pop_front();
            n_checks++; if (rx_got0[b % 64] !== e) begin n_fail++; $display("FAIL b2b_rx_data: got %h want %h", rx_got0[b % 64], e); end
            b++;
        end
        begin
            logic [W-1:0] e1 = tx_exp_q.pop_front();
            logic [W-1:0] e2 = tx_exp_q.pop_front();
            n_checks++; if (rd_b2b[31:16] !== e1) begin n_fail++; $display("FAIL b2b_miso_word1: got %h want %h", rd_b2b[31:16], e1); end
            n_checks++; if (rd_b2b[15:0] !== e2)  begin n_fail++; $display("FAIL b2b_miso_word2: got %h want %h", rd_b2b[15:0], e2); end
        end
        n_checks++; if (udr_cnt0 - u !== 0) begin n_fail++; $display("FAIL b2b_no_underrun: got %0d want 0", udr_cnt0 - u); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] rd;
        int b, f;
        load_tx(0, 16'hC001);
        xfer(0, 32'h0000001F, 5, 0, rd);
        rst = 1'b1;
        #1;
        n_checks++; if (miso0 !== 1'b0)     begin n_fail++; $display("FAIL rstmid_miso: got %b want 0", miso0); end
        n_checks++; if (tx_ready0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready0); end
        n_checks++; if (rx_data0 !== 16'h0) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want 0000", rx_data0); end
        n_checks++; if ({rx_valid0, udr0, ferr0} !== 3'b000) begin n_fail++; $display("FAIL rstmid_pulses: got %b want 000", {rx_valid0, udr0, ferr0}); end
        @(negedge clk);
        ss0 = 1'b1;
        #(4*H);
        rst = 1'b0;
        #(4*H);
        b = rxv_cnt0; f = ferr_cnt0;
        n_checks++; if (ferr_cnt0 + rxv_cnt0 - f - b !== 0) begin n_fail++; $display("FAIL rstmid_silent: got %0d pulses want 0", ferr_cnt0 + rxv_cnt0 - f - b); end
        rx_exp0_q.push_back(16'h0F0F);
        xfer(0, 32'h00000F0F, 16, 1, rd);
        n_checks++; if (rxv_cnt0 - b !== 1) begin n_fail++; $display("FAIL rstmid_rx_pulses: got %0d want 1", rxv_cnt0 - b); end
        while (b < rxv_cnt0 && rx_exp0_q.size() > 0) begin
            logic [W-1:0] e = rx_exp0_q.pop_front();
            n_checks++; if (rx_got0[b % 64] !== e) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want %h", rx_got0[b % 64], e); end
            b++;
        end
        n_checks++; if (ferr_cnt0 - f !== 0) begin n_fail++; $display("FAIL rstmid_no_ferr: got %0d want 0", ferr_cnt0 - f); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_underrun();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        n_checks++;
        if (rx_exp0_q.size() + rx_exp3_q.size() + tx_exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", rx_exp0_q.size() + rx_exp3_q.size() + tx_exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
